// File: rtl/mips_dmem_wbuf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared definitions for the MIPS data-memory write buffer.
//               Holds the default widths/depth, the write-buffer entry type
//               and a word-address compare helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int DATA_MEM_WIDTH = 32;
    localparam int WBUF_DEPTH_DEF = 4;

    // One write-buffer slot. addr/data are stored at the full package width;
    // narrower ADDR_W/DATA_W configurations zero-extend on the way in.
    typedef struct packed {
        logic                      valid;
        logic [DATA_MEM_WIDTH-1:0] addr;
        logic [DATA_MEM_WIDTH-1:0] data;
    } wbuf_entry_t;

    // Two byte addresses refer to the same 32-bit word when they agree above
    // the byte-offset bits.
    function automatic logic word_match(input logic [DATA_MEM_WIDTH-1:0] a,
                                        input logic [DATA_MEM_WIDTH-1:0] b);
        return a[DATA_MEM_WIDTH-1:2] == b[DATA_MEM_WIDTH-1:2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_wbuf_fwd.sv
`default_nettype none
// ============================================================================
// Module      : mips_wbuf_fwd
// Description : Store-to-load match and youngest-entry select for the write
//               buffer. Walks the occupied entries from oldest (head) to
//               youngest; the last match found wins.
// Ports       : entries  - registered buffer slots
//               head     - index of the oldest occupied slot
//               count    - number of occupied slots
//               memaddr  - load address from the core
//               hit      - some occupied, valid slot matches memaddr's word
//               data     - data of the youngest matching slot
// Revision    : 1.0 - initial release
// ============================================================================
module mips_wbuf_fwd
    import mips_pkg::*;
#(
    parameter int DEPTH  = WBUF_DEPTH_DEF,
    parameter int ADDR_W = DATA_MEM_WIDTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  wbuf_entry_t               entries [DEPTH],
    input  logic [PTR_W-1:0]          head,
    input  logic [CNT_W-1:0]          count,
    input  logic [ADDR_W-1:0]         memaddr,
    output logic                      hit,
    output logic [DATA_MEM_WIDTH-1:0] data
);

    logic [PTR_W-1:0] w_idx;

    always_comb begin
        hit   = 1'b0;
        data  = '0;
        w_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            // Age order: k=0 is the head (oldest); wrap is free since DEPTH
            // is a power of two.
            w_idx = head + PTR_W'(k);
            if ((CNT_W'(k) < count) && entries[w_idx].valid &&
                word_match(entries[w_idx].addr, DATA_MEM_WIDTH'(memaddr))) begin
                hit  = 1'b1;
                data = entries[w_idx].data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_dmem_wbuf.sv
`default_nettype none
// ============================================================================
// Module      : mips_dmem_wbuf
// Description : Posted-write buffer between the MIPS core and data RAM.
//               Stores are queued in a circular FIFO and drained in order
//               over a valid/ready handshake; loads read the RAM
//               combinationally.
//               Build option MIPS_WBUF_FWD_EN: when defined, loads are
//               served from the youngest matching buffered store. When
//               undefined, readdata is the raw RAM data and the extra
//               output raw_hazard flags a pending store to the load's word.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               memwrite, memaddr, writedata, readdata - core side
//               mem_w*            - RAM write handshake (head entry)
//               mem_raddr/rdata   - RAM combinational read port
//               wbuf_full/empty/count, overflow - status
//               raw_hazard        - (forwarding disabled only)
// Revision    : 1.0 - initial release
// ============================================================================
module mips_dmem_wbuf
    import mips_pkg::*;
#(
    parameter int DEPTH  = WBUF_DEPTH_DEF,
    parameter int ADDR_W = DATA_MEM_WIDTH,
    parameter int DATA_W = DATA_MEM_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       memwrite,
    input  logic [ADDR_W-1:0]          memaddr,
    input  logic [DATA_W-1:0]          writedata,
    output logic [DATA_W-1:0]          readdata,
    output logic                       mem_wvalid,
    input  logic                       mem_wready,
    output logic [ADDR_W-1:0]          mem_waddr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic [ADDR_W-1:0]          mem_raddr,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       wbuf_full,
    output logic                       wbuf_empty,
    output logic [$clog2(DEPTH):0]     wbuf_count,
    output logic                       overflow
`ifndef MIPS_WBUF_FWD_EN
   ,output logic                       raw_hazard
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wbuf_entry_t      r_ent [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic                      w_full;
    logic                      w_empty;
    logic                      w_pop;
    logic                      w_push;
    logic                      w_fwd_hit;
    logic [DATA_MEM_WIDTH-1:0] w_fwd_data;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && mem_wready;
    // A full buffer still accepts a store when the head leaves this cycle.
    assign w_push  = memwrite && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i].valid <= 1'b0;
            end
        end else begin
            // Pop before push: when full, head==tail and the incoming store
            // must leave the reused slot marked valid.
            if (w_pop) begin
                r_ent[r_head].valid <= 1'b0;
                r_head              <= r_head + 1'b1;
            end
            if (w_push) begin
                r_ent[r_tail].valid <= 1'b1;
                r_ent[r_tail].addr  <= DATA_MEM_WIDTH'(memaddr);
                r_ent[r_tail].data  <= DATA_MEM_WIDTH'(writedata);
                r_tail              <= r_tail + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (memwrite && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign mem_wvalid = !w_empty;
    assign mem_waddr  = r_ent[r_head].addr[ADDR_W-1:0];
    assign mem_wdata  = r_ent[r_head].data[DATA_W-1:0];
    assign mem_raddr  = memaddr;
    assign wbuf_full  = w_full;
    assign wbuf_empty = w_empty;
    assign wbuf_count = r_count;
    assign overflow   = r_overflow;

    // Compares registered entries only, so a store in flight this cycle
    // never matches itself, while the entry being popped still does.
    mips_wbuf_fwd #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fwd (
        .entries (r_ent),
        .head    (r_head),
        .count   (r_count),
        .memaddr (memaddr),
        .hit     (w_fwd_hit),
        .data    (w_fwd_data)
    );

`ifdef MIPS_WBUF_FWD_EN
    assign readdata = w_fwd_hit ? w_fwd_data[DATA_W-1:0] : mem_rdata;
`else
    logic w_unused_fwd_data;
    assign w_unused_fwd_data = ^w_fwd_data;
    assign readdata          = mem_rdata;
    assign raw_hazard        = w_fwd_hit;
`endif

endmodule
`default_nettype wire
